// File: rtl/data_path_if.sv
// Control-strobe and I/O bundle between the control unit (master) and the datapath (slave).
interface data_path_if;
  logic        PCout, Zlowout, Zhighout, HIout, LOout, MDRout, In_Portout, Cout, Baout;
  logic        MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zin_low, Zin_high;
  logic        Gra, Grb, Grc, r_in;
  logic        IncPC, Read, Write, ConIn, inPortenable, outPortenable;
  logic [4:0]  operation;
  logic [31:0] Mdatain;
  logic [31:0] inPort_input;
  logic [31:0] outport_out;

  modport master (
    output PCout, Zlowout, Zhighout, HIout, LOout, MDRout, In_Portout, Cout, Baout,
    output MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zin_low, Zin_high,
    output Gra, Grb, Grc, r_in,
    output IncPC, Read, Write, ConIn, inPortenable, outPortenable,
    output operation, Mdatain, inPort_input,
    input  outport_out
  );

  modport slave (
    input  PCout, Zlowout, Zhighout, HIout, LOout, MDRout, In_Portout, Cout, Baout,
    input  MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zin_low, Zin_high,
    input  Gra, Grb, Grc, r_in,
    input  IncPC, Read, Write, ConIn, inPortenable, outPortenable,
    input  operation, Mdatain, inPort_input,
    output outport_out
  );
endinterface

// File: rtl/data_path.sv
// Single-bus 32-bit datapath: register file, PC/IR, ALU with Y/Z staging, HI/LO,
// MAR/MDR with 512-word RAM, I/O ports and branch-condition flag.
module data_path (
  input  logic        Clock,
  input  logic        clear,
  data_path_if.slave  dp
);

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00000,
    OP_SUB  = 5'b00001,
    OP_AND  = 5'b00010,
    OP_OR   = 5'b00011,
    OP_SHR  = 5'b00100,
    OP_SHRA = 5'b00101,
    OP_SHL  = 5'b00110,
    OP_ROR  = 5'b00111,
    OP_ROL  = 5'b01000,
    OP_MUL  = 5'b01001,
    OP_DIV  = 5'b01010,
    OP_NEG  = 5'b01011,
    OP_NOT  = 5'b01100
  } alu_op_e;

  logic [31:0] r_gpr [16];
  logic [31:0] r_ram [512];
  logic [31:0] r_pc, r_ir, r_y, r_zhi, r_zlo, r_hi, r_lo;
  logic [31:0] r_mar, r_mdr, r_inport, r_outport;
  logic        r_con;

  logic [31:0] w_bus;
  logic [3:0]  w_sel;
  logic [31:0] w_sel_val;
  logic [31:0] w_cval;
  logic        w_other_src;
  logic        w_regout;
  logic        w_mar_int;
  logic [31:0] w_rdata;
  logic [63:0] w_c;
  alu_op_e     w_op;
  logic [4:0]  w_sh;
  logic [63:0] w_ror, w_rol;
  logic signed [31:0] w_as, w_bs;
  logic signed [63:0] w_prod;
  logic signed [31:0] w_quot, w_rem;
  logic [1:0]  w_c2;
  logic        w_unused;

  assign w_sel = ({4{dp.Gra}} & r_ir[26:23]) |
                 ({4{dp.Grb}} & r_ir[22:19]) |
                 ({4{dp.Grc}} & r_ir[18:15]);
  assign w_sel_val = r_gpr[w_sel];
  assign w_cval    = {{13{r_ir[18]}}, r_ir[18:0]};
  assign w_c2      = r_ir[20:19];
  assign w_unused  = ^r_ir[31:27];

  assign w_other_src = dp.Baout | dp.PCout | dp.Zhighout | dp.Zlowout | dp.HIout |
                       dp.LOout | dp.MDRout | dp.In_Portout | dp.Cout;
  assign w_regout    = (dp.Gra | dp.Grb | dp.Grc) & ~dp.r_in & ~w_other_src;

  // Baout reads R0 as constant zero (base-address form); plain register-out does not.
  always_comb begin
    w_bus = '0;
    if (dp.Baout)           w_bus = (w_sel == 4'd0) ? '0 : w_sel_val;
    else if (w_regout)      w_bus = w_sel_val;
    else if (dp.PCout)      w_bus = r_pc;
    else if (dp.Zhighout)   w_bus = r_zhi;
    else if (dp.Zlowout)    w_bus = r_zlo;
    else if (dp.HIout)      w_bus = r_hi;
    else if (dp.LOout)      w_bus = r_lo;
    else if (dp.MDRout)     w_bus = r_mdr;
    else if (dp.In_Portout) w_bus = r_inport;
    else if (dp.Cout)       w_bus = w_cval;
  end

  assign w_mar_int = (r_mar[31:9] == '0);
  assign w_rdata   = w_mar_int ? r_ram[r_mar[8:0]] : dp.Mdatain;

  assign w_op   = alu_op_e'(dp.operation);
  assign w_sh   = w_bus[4:0];
  assign w_ror  = {r_y, r_y} >> w_sh;
  assign w_rol  = {r_y, r_y} << w_sh;
  assign w_as   = $signed(r_y);
  assign w_bs   = $signed(w_bus);
  assign w_prod = 64'(w_as) * 64'(w_bs);
  assign w_quot = (w_bus == '0) ? '1 : (w_as / w_bs);
  assign w_rem  = (w_bus == '0) ? w_as : (w_as % w_bs);

  always_comb begin
    w_c = '0;
    if (dp.IncPC) begin
      w_c = {32'b0, w_bus + 32'd1};
    end else begin
      case (w_op)
        OP_ADD:  w_c = {32'b0, r_y + w_bus};
        OP_SUB:  w_c = {32'b0, r_y - w_bus};
        OP_AND:  w_c = {32'b0, r_y & w_bus};
        OP_OR:   w_c = {32'b0, r_y | w_bus};
        OP_SHR:  w_c = {32'b0, r_y >> w_sh};
        OP_SHRA: w_c = {32'b0, $unsigned(w_as >>> w_sh)};
        OP_SHL:  w_c = {32'b0, r_y << w_sh};
        OP_ROR:  w_c = {32'b0, w_ror[31:0]};
        OP_ROL:  w_c = {32'b0, w_rol[63:32]};
        OP_MUL:  w_c = $unsigned(w_prod);
        OP_DIV:  w_c = {$unsigned(w_rem), $unsigned(w_quot)};
        OP_NEG:  w_c = {32'b0, 32'd0 - w_bus};
        OP_NOT:  w_c = {32'b0, ~w_bus};
        default: w_c = {32'b0, w_bus};
      endcase
    end
  end

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      for (int unsigned i = 0; i < 16; i++) r_gpr[i] <= '0;
      r_pc      <= '0;
      r_ir      <= '0;
      r_y       <= '0;
      r_zhi     <= '0;
      r_zlo     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_mar     <= '0;
      r_mdr     <= '0;
      r_inport  <= '0;
      r_outport <= '0;
      r_con     <= 1'b0;
    end else begin
      if (dp.r_in)          r_gpr[w_sel] <= w_bus;
      if (dp.PCin)          r_pc      <= w_bus;
      if (dp.IRin)          r_ir      <= w_bus;
      if (dp.Yin)           r_y       <= w_bus;
      if (dp.Zin_low)       r_zlo     <= w_c[31:0];
      if (dp.Zin_high)      r_zhi     <= w_c[63:32];
      if (dp.HIin)          r_hi      <= w_bus;
      if (dp.LOin)          r_lo      <= w_bus;
      if (dp.MARin)         r_mar     <= w_bus;
      if (dp.MDRin)         r_mdr     <= dp.Read ? w_rdata : w_bus;
      if (dp.inPortenable)  r_inport  <= dp.inPort_input;
      if (dp.outPortenable) r_outport <= w_bus;
      if (dp.ConIn) begin
        case (w_c2)
          2'b00:   r_con <= (w_bus == '0);
          2'b01:   r_con <= (w_bus != '0);
          2'b10:   r_con <= ~w_bus[31];
          default: r_con <= w_bus[31];
        endcase
      end
    end
  end

  // RAM is deliberately outside the reset domain; out-of-range writes are dropped.
  always_ff @(posedge Clock) begin
    if (dp.Write && w_mar_int) r_ram[r_mar[8:0]] <= r_mdr;
  end

  assign dp.outport_out = r_outport;

endmodule

// File: tb/tb_data_path.sv
// Directed bench for data_path: drives control strobes through the interface and
// checks architectural registers against hand-computed values.
module tb_data_path;
  logic clk;
  logic clear;
  int   tests;
  int   fails;

  data_path_if dp ();

  data_path dut (
    .Clock (clk),
    .clear (clear),
    .dp    (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    dp.PCout = 0; dp.Zlowout = 0; dp.Zhighout = 0; dp.HIout = 0; dp.LOout = 0;
    dp.MDRout = 0; dp.In_Portout = 0; dp.Cout = 0; dp.Baout = 0;
    dp.MARin = 0; dp.PCin = 0; dp.MDRin = 0; dp.IRin = 0; dp.Yin = 0;
    dp.HIin = 0; dp.LOin = 0; dp.Zin_low = 0; dp.Zin_high = 0;
    dp.Gra = 0; dp.Grb = 0; dp.Grc = 0; dp.r_in = 0;
    dp.IncPC = 0; dp.Read = 0; dp.Write = 0; dp.ConIn = 0;
    dp.inPortenable = 0; dp.outPortenable = 0; dp.operation = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Loads the in-port register; the following step drives it onto the bus.
  task automatic put(input logic [31:0] v);
    dp.inPort_input = v;
    dp.inPortenable = 1;
    tick();
    idle();
  endtask

  task automatic alu(input logic [4:0] op, input logic use_r);
    dp.operation = op;
    dp.Gra = use_r;
    dp.Zin_low = 1;
    dp.Zin_high = 1;
    tick();
    idle();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    idle();
    dp.Mdatain = 32'hCAFEF00D;
    dp.inPort_input = '0;
    clear = 1'b0;
    #12 clear = 1'b1;
    chk("rst_outport", dp.outport_out, 32'h0);
    chk("rst_pc", dut.r_pc, 32'h0);

    // Preload R3, PC, outport; then async clear between edges
    put(32'h01800000);
    dp.In_Portout = 1; dp.IRin = 1; tick(); idle();
    put(32'h12345678);
    dp.In_Portout = 1; dp.Gra = 1; dp.r_in = 1; dp.PCin = 1; dp.outPortenable = 1; tick(); idle();
    chk("pre_r3", dut.r_gpr[3], 32'h12345678);
    chk("pre_pc", dut.r_pc, 32'h12345678);
    chk("pre_out", dp.outport_out, 32'h12345678);
    #2 clear = 1'b0;
    #1;
    chk("clr_r3", dut.r_gpr[3], 32'h0);
    chk("clr_pc", dut.r_pc, 32'h0);
    chk("clr_ir", dut.r_ir, 32'h0);
    chk("clr_out", dp.outport_out, 32'h0);
    clear = 1'b1;

    // Fetch: place instruction at RAM[0] (MAR=0 after clear)
    put(32'h0A980000);
    dp.In_Portout = 1; dp.MDRin = 1; tick(); idle();
    dp.Write = 1; tick(); idle();
    put(32'h0);
    dp.In_Portout = 1; dp.MDRin = 1; tick(); idle();
    dp.PCout = 1; dp.MARin = 1; dp.IncPC = 1; dp.Zin_low = 1; tick(); idle();
    chk("t0_mar", dut.r_mar, 32'h0);
    chk("t0_zlo", dut.r_zlo, 32'h1);
    dp.Zlowout = 1; dp.PCin = 1; dp.Read = 1; dp.MDRin = 1; tick(); idle();
    chk("t1_pc", dut.r_pc, 32'h1);
    chk("t1_mdr", dut.r_mdr, 32'h0A980000);
    dp.MDRout = 1; dp.IRin = 1; tick(); idle();
    chk("t2_ir", dut.r_ir, 32'h0A980000);

    // Jump-register: IR Ra=5
    put(32'h00000040);
    dp.In_Portout = 1; dp.Gra = 1; dp.r_in = 1; tick(); idle();
    chk("r5", dut.r_gpr[5], 32'h40);
    dp.Gra = 1; dp.PCin = 1; tick(); idle();
    chk("jr_pc", dut.r_pc, 32'h40);

    // ALU: IR Ra=2, R2=3, Y=7
    put(32'h01000000);
    dp.In_Portout = 1; dp.IRin = 1; tick(); idle();
    put(32'd3);
    dp.In_Portout = 1; dp.Gra = 1; dp.r_in = 1; tick(); idle();
    put(32'd7);
    dp.In_Portout = 1; dp.Yin = 1; tick(); idle();
    alu(5'b00000, 1); chk("add", dut.r_zlo, 32'd10);
    alu(5'b00001, 1); chk("sub", dut.r_zlo, 32'd4);
    chk("sub_hi", dut.r_zhi, 32'd0);
    alu(5'b00010, 1); chk("and", dut.r_zlo, 32'd3);
    alu(5'b00011, 1); chk("or", dut.r_zlo, 32'd7);
    alu(5'b00110, 1); chk("shl", dut.r_zlo, 32'h38);
    alu(5'b00111, 1); chk("ror", dut.r_zlo, 32'hE0000000);
    alu(5'b01000, 1); chk("rol", dut.r_zlo, 32'h38);
    alu(5'b01010, 1); chk("div_q", dut.r_zlo, 32'd2);
    chk("div_r", dut.r_zhi, 32'd1);
    alu(5'b01011, 1); chk("neg", dut.r_zlo, 32'hFFFFFFFD);
    alu(5'b01100, 1); chk("not", dut.r_zlo, 32'hFFFFFFFC);
    alu(5'b11111, 1); chk("pass", dut.r_zlo, 32'd3);
    put(32'hFFFFFFFE);
    dp.In_Portout = 1; dp.Yin = 1; tick(); idle();
    alu(5'b01001, 1);
    chk("mul_hi", dut.r_zhi, 32'hFFFFFFFF);
    chk("mul_lo", dut.r_zlo, 32'hFFFFFFFA);
    alu(5'b00101, 1); chk("shra", dut.r_zlo, 32'hFFFFFFFF);
    alu(5'b00100, 1); chk("shr", dut.r_zlo, 32'h1FFFFFFF);
    put(32'd7);
    dp.In_Portout = 1; dp.Yin = 1; tick(); idle();
    alu(5'b01010, 0);
    chk("div0_q", dut.r_zlo, 32'hFFFFFFFF);
    chk("div0_r", dut.r_zhi, 32'd7);

    // Baout vs register-out of R0, IR=0x10 (Ra=Rb=0, C=0x10)
    put(32'h00000010);
    dp.In_Portout = 1; dp.IRin = 1; tick(); idle();
    put(32'h99);
    dp.In_Portout = 1; dp.Gra = 1; dp.r_in = 1; dp.outPortenable = 1; tick(); idle();
    chk("r0_write", dut.r_gpr[0], 32'h99);
    dp.Grb = 1; dp.Baout = 1; dp.outPortenable = 1; tick(); idle();
    chk("baout_r0", dp.outport_out, 32'h0);
    dp.Grb = 1; dp.outPortenable = 1; tick(); idle();
    chk("regout_r0", dp.outport_out, 32'h99);
    dp.Cout = 1; dp.MARin = 1; tick(); idle();
    chk("cout_mar", dut.r_mar, 32'h10);

    // RAM write / read-back / read-during-write
    put(32'hDEADBEEF);
    dp.In_Portout = 1; dp.MDRin = 1; tick(); idle();
    dp.Write = 1; tick(); idle();
    put(32'h0);
    dp.In_Portout = 1; dp.MDRin = 1; tick(); idle();
    dp.Read = 1; dp.MDRin = 1; tick(); idle();
    chk("ram_rd", dut.r_mdr, 32'hDEADBEEF);
    put(32'h11111111);
    dp.In_Portout = 1; dp.MDRin = 1; tick(); idle();
    dp.Write = 1; dp.Read = 1; dp.MDRin = 1; tick(); idle();
    chk("rdw_old", dut.r_mdr, 32'hDEADBEEF);
    dp.Read = 1; dp.MDRin = 1; tick(); idle();
    chk("rdw_new", dut.r_mdr, 32'h11111111);

    // External space: MAR=0x200 reads Mdatain, writes are dropped
    put(32'h200);
    dp.In_Portout = 1; dp.MARin = 1; tick(); idle();
    dp.Read = 1; dp.MDRin = 1; tick(); idle();
    chk("ext_rd", dut.r_mdr, 32'hCAFEF00D);
    dp.Write = 1; tick(); idle();
    put(32'h0);
    dp.In_Portout = 1; dp.MARin = 1; tick(); idle();
    dp.Read = 1; dp.MDRin = 1; tick(); idle();
    chk("ext_wr_drop", dut.r_mdr, 32'h0A980000);

    // Cout sign extension
    put(32'h00040000);
    dp.In_Portout = 1; dp.IRin = 1; tick(); idle();
    dp.Cout = 1; dp.outPortenable = 1; tick(); idle();
    chk("cout_sext", dp.outport_out, 32'hFFFC0000);

    // CON: C2=01 then C2=00 with bus=5
    put(32'h00080000);
    dp.In_Portout = 1; dp.IRin = 1; tick(); idle();
    put(32'd5);
    dp.In_Portout = 1; dp.ConIn = 1; tick(); idle();
    chk("con_ne", {31'b0, dut.r_con}, 32'd1);
    put(32'h00000000);
    dp.In_Portout = 1; dp.IRin = 1; tick(); idle();
    put(32'd5);
    dp.In_Portout = 1; dp.ConIn = 1; tick(); idle();
    chk("con_eq", {31'b0, dut.r_con}, 32'd0);

    // I/O path
    put(32'h55);
    dp.In_Portout = 1; dp.outPortenable = 1; tick(); idle();
    chk("io_out", dp.outport_out, 32'h55);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/data_path.md
# data_path

Single-bus 32-bit processor datapath: sixteen general registers, PC, IR, ALU with Y/Z staging, HI/LO, MAR/MDR with a 512-word internal RAM, I/O port registers and a branch-condition flag. Every transfer runs over one shared 32-bit bus and is steered by explicit control strobes from the control unit or a testbench, one register transfer per clock. It sits between the control FSM and the I/O pins.

## Interface
- No parameters.
- Clock  in  1  rising-edge clock for all state.
- clear  in  1  asynchronous, active-low reset.
- PCout, Zlowout, Zhighout, HIout, LOout, MDRout, In_Portout, Cout, Baout  in  1 each  bus-drive strobes.
- MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zin_low, Zin_high  in  1 each  register-load strobes.
- Gra, Grb, Grc  in  1 each  select general register by IR field Ra/Rb/Rc.
- r_in  in  1  load selected general register from bus.
- IncPC  in  1  ALU computes bus+1, overriding operation.
- Read  in  1  MDR source = memory (otherwise bus).
- Write  in  1  write MDR to RAM[MAR].
- ConIn  in  1  load CON flag.
- inPortenable  in  1  load in-port register from inPort_input.
- outPortenable  in  1  load out-port register from bus.
- operation  in  5  ALU opcode.
- Mdatain  in  32  external memory data for addresses ≥ 512.
- inPort_input  in  32  external input-port data.
- outport_out  out  32  out-port register contents.

## Operation
- Bus: one driver per cycle by priority Baout/register-out, PCout, Zhighout, Zlowout, HIout, LOout, MDRout, In_Portout, Cout. No driver: bus = 0.
- IR fields: Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15], C2=IR[20:19]. Cout drives IR[18:0] sign-extended to 32 bits.
- Register select: index = OR of (Gra&Ra, Grb&Rb, Grc&Rc). The selected register drives the bus when any Gr* is high, r_in=0 and no other bus strobe is high. Baout drives the selected register, except selected R0 drives 0. r_in writes the selected register. R0 is writable.
- ALU operands: A=Y, B=bus. Output is a 64-bit result C. Zin_low loads ZLO=C[31:0]; Zin_high loads ZHI=C[63:32].
- Opcodes:
  - 00000 ADD, 00001 SUB, 00010 AND, 00011 OR.
  - 00100 SHR (logical), 00101 SHRA (arithmetic), 00110 SHL, 00111 ROR, 01000 ROL. Shift/rotate amount is B[4:0].
  - 01001 MUL: signed 64-bit product.
  - 01010 DIV: signed; quotient in low 32 bits, remainder in high 32 bits. B=0 gives quotient 0xFFFFFFFF, remainder A.
  - 01011 NEG: −B. 01100 NOT: ~B.
  - All other codes: pass B.
  - For non-MUL/DIV ops, C[63:32] = 0. IncPC forces C = {32'b0, B+1}.
- Memory: RAM is 512×32, indexed by MAR[8:0], not cleared by reset. Read data comes from RAM if MAR[31:9]=0, else Mdatain.
- MDR: on MDRin, loads read data if Read=1, else the bus.
- CON: on ConIn, loads (C2=00: bus==0; 01: bus!=0; 10: bus[31]==0; 11: bus[31]==1).
- In-port register: loads inPort_input when inPortenable=1. Out-port register: loads bus when outPortenable=1.

## Timing
- All registers load at rising Clock when their enable is high. Simultaneous loads of several registers from the same bus value are legal.
- Bus, ALU, register select and memory read are combinational within a cycle. A source strobe and a destination strobe asserted in the same cycle complete in one clock.
- RAM write is synchronous: at a rising edge with Write=1, RAM[MAR[8:0]] <= MDR (pre-edge value). A write with MAR ≥ 512 is discarded.
- Read and write to the same address in the same cycle: the read returns old data.
- clear=0 asynchronously zeroes R0–R15, PC, IR, Y, ZHI, ZLO, HI, LO, MAR, MDR, in-port, out-port and CON. outport_out = 0 during reset.
- Reset mid-transfer aborts it; the first load takes effect at the first rising edge after clear returns high.

## Test plan
- Reset: preload R3, PC, outport; pulse clear low between edges → all read 0 immediately, outport_out = 0.
- Fetch: RAM[0]=0x0A980000, PC=0. Then:
  - T0: PCout, MARin, IncPC, Zin_low → MAR=0, ZLO=1.
  - T1: Zlowout, PCin, Read, MDRin → PC=1, MDR=0x0A980000.
  - T2: MDRout, IRin → IR=0x0A980000.
- Jump-register: R5=0x00000040, IR with Ra=5; assert Gra+PCin one cycle → PC=0x40.
- ALU: Y=7, bus=R2=3. SUB → ZLO=4. MUL with Y=−2, B=3 → ZHI=0xFFFFFFFF, ZLO=0xFFFFFFFA. DIV 7/3 → ZLO=2, ZHI=1. DIV by 0 → ZLO=0xFFFFFFFF, ZHI=7.
- Memory/Baout: IR Rb=0 with C=0x10, Grb+Baout → bus 0. MAR=0x10, MDR=0xDEADBEEF, Write → RAM[0x10] updated; Read+MDRin returns 0xDEADBEEF. MAR=0x200 reads Mdatain.
- CON/IO: C2=01, bus=5, ConIn → CON=1. inPort_input=0x55 with inPortenable, then In_Portout+outPortenable → outport_out=0x55.
